// File: rtl/fp_add_sched_pkg.sv
// Shared types and constants for the fp_add_scheduler front-end.
// Holds the FSM state enum, requester-ID type and latency-counter width.
package fp_add_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int LAT_W              = 4;

    typedef logic             req_id_t;
    typedef logic [LAT_W-1:0] lat_cnt_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and under
// contention the requester that was not granted last time wins.
module rr_arbiter2
    import fp_add_sched_pkg::*;
(
    input  logic       valid0_in,
    input  logic       valid1_in,
    input  req_id_t    last_grant_in,
    output logic [1:0] grant_out
);

    always_comb begin
        grant_out    = 2'b00;
        grant_out[0] = valid0_in && (!valid1_in || (last_grant_in == 1'b1));
        grant_out[1] = valid1_in && (!valid0_in || (last_grant_in == 1'b0));
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Arbitrates two requesters onto one shared fp add/sub datapath, holds operands
// for DP_LATENCY edges and returns the tagged result. Grant counters: FP_ADD_SCHED_STATS_EN.
module fp_add_scheduler
    import fp_add_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DP_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  req0_valid_in,
    output logic                  req0_ready_out,
    input  logic [DATA_WIDTH-1:0] req0_op1_in,
    input  logic [DATA_WIDTH-1:0] req0_op2_in,
    input  logic                  req0_opcode_in,
    input  logic                  req1_valid_in,
    output logic                  req1_ready_out,
    input  logic [DATA_WIDTH-1:0] req1_op1_in,
    input  logic [DATA_WIDTH-1:0] req1_op2_in,
    input  logic                  req1_opcode_in,
    output logic                  res_valid_out,
    input  logic                  res_ready_in,
    output logic [DATA_WIDTH-1:0] res_data_out,
    output logic                  res_id_out,
    output logic [DATA_WIDTH-1:0] dp_floating1_out,
    output logic [DATA_WIDTH-1:0] dp_floating2_out,
    output logic                  dp_opcode_out,
    input  logic [DATA_WIDTH-1:0] dp_result_in
`ifdef FP_ADD_SCHED_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  grant0_cnt_out,
    output logic [CNT_WIDTH-1:0]  grant1_cnt_out
`endif
);

    if ((DP_LATENCY < 1) || (DP_LATENCY > 15)) begin : g_bad_latency
        $error("DP_LATENCY must be in 1..15");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    sched_state_e          state_q;
    req_id_t               last_grant_q;
    req_id_t               res_id_q;
    lat_cnt_t              lat_cnt_q;
    logic                  res_valid_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [DATA_WIDTH-1:0] dp_op1_q;
    logic [DATA_WIDTH-1:0] dp_op2_q;
    logic                  dp_opcode_q;

    logic [1:0]            grant;
    logic                  accept_d;
    req_id_t               win_id_d;
    logic [DATA_WIDTH-1:0] op1_d;
    logic [DATA_WIDTH-1:0] op2_d;
    logic                  opcode_d;

    rr_arbiter2 u_arb (
        .valid0_in     (req0_valid_in),
        .valid1_in     (req1_valid_in),
        .last_grant_in (last_grant_q),
        .grant_out     (grant)
    );

    // Grant is only ever asserted for a valid requester, so IDLE && grant is valid&&ready.
    always_comb begin
        win_id_d = grant[1];
        accept_d = (state_q == ST_IDLE) && (grant != 2'b00);
        op1_d    = win_id_d ? req1_op1_in    : req0_op1_in;
        op2_d    = win_id_d ? req1_op2_in    : req0_op2_in;
        opcode_d = win_id_d ? req1_opcode_in : req0_opcode_in;
    end

    assign req0_ready_out   = (state_q == ST_IDLE) && grant[0];
    assign req1_ready_out   = (state_q == ST_IDLE) && grant[1];
    assign res_valid_out    = res_valid_q;
    assign res_data_out     = res_data_q;
    assign res_id_out       = res_id_q;
    assign dp_floating1_out = dp_op1_q;
    assign dp_floating2_out = dp_op2_q;
    assign dp_opcode_out    = dp_opcode_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            res_id_q     <= 1'b0;
            lat_cnt_q    <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            dp_op1_q     <= '0;
            dp_op2_q     <= '0;
            dp_opcode_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        dp_op1_q     <= op1_d;
                        dp_op2_q     <= op2_d;
                        dp_opcode_q  <= opcode_d;
                        res_id_q     <= win_id_d;
                        last_grant_q <= win_id_d;
                        lat_cnt_q    <= lat_cnt_t'(DP_LATENCY);
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    lat_cnt_q <= lat_cnt_q - 1'b1;
                    if (lat_cnt_q == lat_cnt_t'(1)) begin
                        res_data_q  <= dp_result_in;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_ready_in) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef FP_ADD_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] grant0_cnt_q;
    logic [CNT_WIDTH-1:0] grant1_cnt_q;

    // Counters wrap naturally from all-ones to zero.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
        end else if (accept_d) begin
            if (win_id_d) grant1_cnt_q <= grant1_cnt_q + 1'b1;
            else          grant0_cnt_q <= grant0_cnt_q + 1'b1;
        end
    end

    assign grant0_cnt_out = grant0_cnt_q;
    assign grant1_cnt_out = grant1_cnt_q;
`endif

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: one instance with a combinational datapath and one with a
// 3-stage latency, both fed by a real-number fp add/sub model. Counters: FP_ADD_SCHED_STATS_EN.
module tb_fp_add_scheduler;

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        opc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, opc0 = 1'b0, opc1 = 1'b0, res_ready = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        use3 = 1'b0;
    int          lat = 1;
    int          n_chk = 0;
    int          n_pass = 0;

    logic        rdy0_1, rdy1_1, rv_1, rid_1, dopc_1;
    logic [31:0] rd_1, dfa_1, dfb_1, dpres_1;
    logic        rdy0_3, rdy1_3, rv_3, rid_3, dopc_3;
    logic [31:0] rd_3, dfa_3, dfb_3, dpres_3;
    logic        rdy0, rdy1, rv, rid, dopc;
    logic [31:0] rd, dfa, dfb;
`ifdef FP_ADD_SCHED_STATS_EN
    logic [15:0] g0_1, g1_1, g0_3, g1_3, g0, g1;
`endif

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] bits);
        real m;
        int  e;
        if (bits[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(bits[22:0]) / 8388608.0;
        e = int'(bits[30:23]) - 127;
        for (int i = 0; i < e; i++) m = m * 2.0;
        for (int i = 0; i < -e; i++) m = m / 2.0;
        return bits[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic        s;
        int          e;
        real         m;
        logic [22:0] fr;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        fr = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e + 127), fr};
    endfunction

    function automatic logic [31:0] fp_model(input logic [31:0] x, input logic [31:0] y, input logic op);
        return r2f(op ? (f2r(x) - f2r(y)) : (f2r(x) + f2r(y)));
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    always_comb dpres_1 = fp_model(dfa_1, dfb_1, dopc_1);
    always_comb dpres_3 = fp_model(dfa_3, dfb_3, dopc_3);

    always_comb begin
        if (use3) begin
            rdy0 = rdy0_3; rdy1 = rdy1_3; rv = rv_3; rid = rid_3; dopc = dopc_3;
            rd = rd_3; dfa = dfa_3; dfb = dfb_3;
        end else begin
            rdy0 = rdy0_1; rdy1 = rdy1_1; rv = rv_1; rid = rid_1; dopc = dopc_1;
            rd = rd_1; dfa = dfa_1; dfb = dfb_1;
        end
`ifdef FP_ADD_SCHED_STATS_EN
        g0 = use3 ? g0_3 : g0_1;
        g1 = use3 ? g1_3 : g1_1;
`endif
    end

    fp_add_scheduler #(.DATA_WIDTH(32), .DP_LATENCY(1), .CNT_WIDTH(16)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n),
        .req0_valid_in(v0), .req0_ready_out(rdy0_1), .req0_op1_in(a0), .req0_op2_in(b0), .req0_opcode_in(opc0),
        .req1_valid_in(v1), .req1_ready_out(rdy1_1), .req1_op1_in(a1), .req1_op2_in(b1), .req1_opcode_in(opc1),
        .res_valid_out(rv_1), .res_ready_in(res_ready), .res_data_out(rd_1), .res_id_out(rid_1),
        .dp_floating1_out(dfa_1), .dp_floating2_out(dfb_1), .dp_opcode_out(dopc_1), .dp_result_in(dpres_1)
`ifdef FP_ADD_SCHED_STATS_EN
        , .grant0_cnt_out(g0_1), .grant1_cnt_out(g1_1)
`endif
    );

    fp_add_scheduler #(.DATA_WIDTH(32), .DP_LATENCY(3), .CNT_WIDTH(16)) u_dut3 (
        .clk_in(clk), .rst_n_in(rst_n),
        .req0_valid_in(v0), .req0_ready_out(rdy0_3), .req0_op1_in(a0), .req0_op2_in(b0), .req0_opcode_in(opc0),
        .req1_valid_in(v1), .req1_ready_out(rdy1_3), .req1_op1_in(a1), .req1_op2_in(b1), .req1_opcode_in(opc1),
        .res_valid_out(rv_3), .res_ready_in(res_ready), .res_data_out(rd_3), .res_id_out(rid_3),
        .dp_floating1_out(dfa_3), .dp_floating2_out(dfb_3), .dp_opcode_out(dopc_3), .dp_result_in(dpres_3)
`ifdef FP_ADD_SCHED_STATS_EN
        , .grant0_cnt_out(g0_3), .grant1_cnt_out(g1_3)
`endif
    );

    task automatic do_reset();
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; opc0 = 1'b0; opc1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++; if ({rdy0_1, rdy1_1, rv_1, rid_1, dopc_1, rd_1, dfa_1, dfb_1} !== '0)
            $display("FAIL reset_outs_l1 got %h exp 0", {rdy0_1, rdy1_1, rv_1, rid_1, dopc_1, rd_1, dfa_1, dfb_1}); else n_pass++;
        n_chk++; if ({rdy0_3, rdy1_3, rv_3, rid_3, dopc_3, rd_3, dfa_3, dfb_3} !== '0)
            $display("FAIL reset_outs_l3 got %h exp 0", {rdy0_3, rdy1_3, rv_3, rid_3, dopc_3, rd_3, dfa_3, dfb_3}); else n_pass++;
`ifdef FP_ADD_SCHED_STATS_EN
        n_chk++; if ({g0_1, g1_1, g0_3, g1_3} !== '0)
            $display("FAIL reset_cnts got %h exp 0", {g0_1, g1_1, g0_3, g1_3}); else n_pass++;
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        use3 = 1'b0; lat = 1;
        do_reset();
        v0 = 1'b1; a0 = 32'h3F800000; b0 = 32'h3F800000; opc0 = 1'b0;
        #1;
        n_chk++; if ({rdy0, rdy1} !== 2'b10) $display("FAIL single_ready got %b exp 10", {rdy0, rdy1}); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        n_chk++; if (rv !== 1'b0) $display("FAIL single_rv_exec got %b exp 0", rv); else n_pass++;
        n_chk++; if ({dfa, dfb, dopc} !== {32'h3F800000, 32'h3F800000, 1'b0})
            $display("FAIL single_dp got %h %h %b exp 3f800000 3f800000 0", dfa, dfb, dopc); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++; if (rv !== 1'b1) $display("FAIL single_rv got %b exp 1", rv); else n_pass++;
        n_chk++; if (rd !== 32'h40000000) $display("FAIL single_data got %h exp 40000000", rd); else n_pass++;
        n_chk++; if (rid !== 1'b0) $display("FAIL single_id got %b exp 0", rid); else n_pass++;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_chk++; if (rv !== 1'b0) $display("FAIL single_rv_drop got %b exp 0", rv); else n_pass++;
    endtask

    task automatic test_contention();
        logic [31:0] pa0[4], pb0[4], pa1[4], pb1[4];
        logic        po0[4], po1[4];
        int          idx0, idx1, k, cyc;
        logic [31:0] exp_d;
        logic        exp_id;
        use3 = 1'b0; lat = 1;
        do_reset();
        pa0[0] = 32'h3F800000; pb0[0] = 32'h3F800000; po0[0] = 1'b0;
        pa1[0] = 32'h40400000; pb1[0] = 32'h3F800000; po1[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            pa0[i] = rand_fp(); pb0[i] = rand_fp(); po0[i] = 1'($urandom);
            pa1[i] = rand_fp(); pb1[i] = rand_fp(); po1[i] = 1'($urandom);
        end
        idx0 = 0; idx1 = 0; k = 0; cyc = 0;
        res_ready = 1'b1;
        while (k < 8 && cyc < 200) begin
            v0 = (idx0 < 4); v1 = (idx1 < 4);
            if (idx0 < 4) begin a0 = pa0[idx0]; b0 = pb0[idx0]; opc0 = po0[idx0]; end
            if (idx1 < 4) begin a1 = pa1[idx1]; b1 = pb1[idx1]; opc1 = po1[idx1]; end
            #1;
            if (rv) begin
                exp_id = k[0];
                if (k < 2) exp_d = 32'h40000000;
                else if (exp_id) exp_d = fp_model(pa1[k/2], pb1[k/2], po1[k/2]);
                else exp_d = fp_model(pa0[k/2], pb0[k/2], po0[k/2]);
                n_chk++; if (rid !== exp_id) $display("FAIL contention_id op %0d got %b exp %b", k, rid, exp_id); else n_pass++;
                n_chk++; if (rd !== exp_d) $display("FAIL contention_data op %0d got %h exp %h", k, rd, exp_d); else n_pass++;
                k++;
            end
            if (v0 && rdy0) idx0++;
            if (v1 && rdy1) idx1++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        n_chk++; if (k != 8) $display("FAIL contention_timeout got %0d results exp 8", k); else n_pass++;
`ifdef FP_ADD_SCHED_STATS_EN
        n_chk++; if ({g0, g1} !== {16'd4, 16'd4}) $display("FAIL contention_cnts got %0d %0d exp 4 4", g0, g1); else n_pass++;
`endif
        v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d, exp_d0;
        use3 = 1'b0; lat = 1;
        do_reset();
        v1 = 1'b1; a1 = rand_fp(); b1 = rand_fp(); opc1 = 1'b1;
        exp_d = fp_model(a1, b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b1; a0 = rand_fp(); b0 = rand_fp(); opc0 = 1'b0;
        a1 = rand_fp(); b1 = rand_fp();
        exp_d0 = fp_model(a0, b0, 1'b0);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_chk++; if ({rv, rid, rd} !== {1'b1, 1'b1, exp_d})
                $display("FAIL bp_hold cyc %0d got %b %b %h exp 1 1 %h", i, rv, rid, rd, exp_d); else n_pass++;
            n_chk++; if ({rdy0, rdy1} !== 2'b00) $display("FAIL bp_ready cyc %0d got %b exp 00", i, {rdy0, rdy1}); else n_pass++;
            @(posedge clk);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_chk++; if ({rv, rdy0, rdy1} !== 3'b010) $display("FAIL bp_after_hs got %b exp 010", {rv, rdy0, rdy1}); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++; if ({rv, rid, rd} !== {1'b1, 1'b0, exp_d0})
            $display("FAIL bp_next got %b %b %h exp 1 0 %h", rv, rid, rd, exp_d0); else n_pass++;
        v1 = 1'b0;
    endtask

    task automatic test_pipelined();
        logic [31:0] pa, pb;
        use3 = 1'b1; lat = 3;
        do_reset();
        pa = rand_fp(); pb = rand_fp();
        v0 = 1'b1; a0 = pa; b0 = pb; opc0 = 1'b1;
        @(posedge clk);
        for (int e = 0; e <= 3; e++) begin
            @(negedge clk);
            if (e == 0) begin v0 = 1'b0; a0 = rand_fp(); b0 = rand_fp(); opc0 = 1'b0; end
            #1;
            n_chk++; if (rv !== (e == 3)) $display("FAIL pipe_rv edge %0d got %b exp %b", e, rv, (e == 3)); else n_pass++;
            n_chk++; if ({dfa, dfb, dopc} !== {pa, pb, 1'b1})
                $display("FAIL pipe_dp edge %0d got %h %h %b exp %h %h 1", e, dfa, dfb, dopc, pa, pb); else n_pass++;
            if (e < 3) @(posedge clk);
        end
        n_chk++; if ({rid, rd} !== {1'b0, fp_model(pa, pb, 1'b1)})
            $display("FAIL pipe_data got %b %h exp 0 %h", rid, rd, fp_model(pa, pb, 1'b1)); else n_pass++;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        use3 = 1'b1; lat = 3;
        do_reset();
        v0 = 1'b1; a0 = rand_fp(); b0 = rand_fp(); opc0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++; if ({rdy0, rdy1, rv, rid, dopc, rd, dfa, dfb} !== '0)
            $display("FAIL midrst_outs got %h exp 0", {rdy0, rdy1, rv, rid, dopc, rd, dfa, dfb}); else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            n_chk++; if (rv !== 1'b0) $display("FAIL midrst_no_result cyc %0d got %b exp 0", i, rv); else n_pass++;
        end
        v0 = 1'b1; v1 = 1'b1;
        #1;
        n_chk++; if ({rdy0, rdy1} !== 2'b10) $display("FAIL midrst_first_grant got %b exp 10", {rdy0, rdy1}); else n_pass++;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_random(input logic sel, input int target);
        exp_t        exp_q[$];
        exp_t        e;
        logic        busy, exp_rv, has_w, w, model_last, acc_now;
        int          cyc, done, acc0, acc1;
        logic [31:0] exp_d;
        use3 = sel; lat = sel ? 3 : 1;
        do_reset();
        model_last = 1'b1; cyc = 0; done = 0; acc0 = 0; acc1 = 0;
        while (done < target && cyc < 3000) begin
            if (!v0 && $urandom_range(0, 2) == 0) begin a0 = rand_fp(); b0 = rand_fp(); opc0 = 1'($urandom); v0 = 1'b1; end
            if (!v1 && $urandom_range(0, 2) == 0) begin a1 = rand_fp(); b1 = rand_fp(); opc1 = 1'($urandom); v1 = 1'b1; end
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            busy = (exp_q.size() != 0);
            exp_rv = 1'b0;
            if (busy) exp_rv = (cyc >= exp_q[0].due);
            has_w = !busy && (v0 || v1);
            w = (v0 && v1) ? ~model_last : v1;
            n_chk++; if ({rdy0, rdy1} !== {has_w && !w, has_w && w})
                $display("FAIL rand_ready L%0d cyc %0d got %b exp %b", lat, cyc, {rdy0, rdy1}, {has_w && !w, has_w && w}); else n_pass++;
            n_chk++; if (rv !== exp_rv) $display("FAIL rand_rv L%0d cyc %0d got %b exp %b", lat, cyc, rv, exp_rv); else n_pass++;
            if (busy) begin
                n_chk++; if ({dfa, dfb, dopc} !== {exp_q[0].a, exp_q[0].b, exp_q[0].opc})
                    $display("FAIL rand_dp L%0d cyc %0d got %h %h %b exp %h %h %b", lat, cyc, dfa, dfb, dopc,
                             exp_q[0].a, exp_q[0].b, exp_q[0].opc); else n_pass++;
            end
            if (exp_rv) begin
                exp_d = fp_model(exp_q[0].a, exp_q[0].b, exp_q[0].opc);
                n_chk++; if ({rid, rd} !== {exp_q[0].id, exp_d})
                    $display("FAIL rand_result L%0d cyc %0d got %b %h exp %b %h", lat, cyc, rid, rd, exp_q[0].id, exp_d); else n_pass++;
                if (res_ready) begin void'(exp_q.pop_front()); done++; end
            end
            acc_now = has_w;
            if (acc_now) begin
                e.due = cyc + 1 + lat; e.id = w;
                e.a = w ? a1 : a0; e.b = w ? b1 : b0; e.opc = w ? opc1 : opc0;
                exp_q.push_back(e);
                model_last = w;
                if (w) acc1++; else acc0++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (acc_now) begin
                if (w) v1 = 1'b0; else v0 = 1'b0;
            end
        end
        n_chk++; if (done < target) $display("FAIL rand_timeout L%0d got %0d results exp %0d", lat, done, target); else n_pass++;
`ifdef FP_ADD_SCHED_STATS_EN
        n_chk++; if ({g0, g1} !== {16'(acc0), 16'(acc1)})
            $display("FAIL rand_cnts L%0d got %0d %0d exp %0d %0d", lat, g0, g1, acc0, acc1); else n_pass++;
`endif
        v0 = 1'b0; v1 = 1'b0; res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_pipelined();
        test_reset_mid();
        test_random(1'b0, 40);
        test_random(1'b1, 40);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
